// File: rtl/fpga2hps_mailbox_pkg.sv
// rtl/fpga2hps_mailbox_pkg.sv - shared widths, pio_out layout and FSM states for the mailbox
package fpga2hps_mailbox_pkg;

    localparam int TYPE_W  = 4;
    localparam int SEQ_W   = 3;
    localparam int DATA_W  = 24;
    localparam int FIFO_W  = TYPE_W + DATA_W;
    localparam int LEVEL_W = 5;

    localparam int PIO_STB     = 31;
    localparam int PIO_TYPE_HI = 30;
    localparam int PIO_TYPE_LO = 27;
    localparam int PIO_SEQ_HI  = 26;
    localparam int PIO_SEQ_LO  = 24;
    localparam int PIO_DATA_HI = 23;
    localparam int PIO_DATA_LO = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        VALID   = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/mailbox_fifo.sv
// rtl/mailbox_fifo.sv - synchronous message FIFO with occupancy count
module mailbox_fifo
    import fpga2hps_mailbox_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FIFO_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_wdata,
    input  logic               i_pop,
    output logic [WIDTH-1:0]   o_rdata,
    output logic               o_empty,
    output logic               o_full,
    output logic [LEVEL_W-1:0] o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_level == LEVEL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents are don't-care until written, so it carries no reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves the level unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + LEVEL_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - LEVEL_W'(1);
            end
        end
    end

endmodule

// File: rtl/fpga2hps_mailbox.sv
// rtl/fpga2hps_mailbox.sv - buffered FPGA-to-HPS message mailbox with four-phase PIO handshake
module fpga2hps_mailbox
    import fpga2hps_mailbox_pkg::*;
#(
    parameter int          FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               msg_valid,
    output logic               msg_ready,
    input  logic [TYPE_W-1:0]  msg_type,
    input  logic [DATA_W-1:0]  msg_data,
    input  logic               hps_ack,
    input  logic               clear_err,
    output logic [31:0]        pio_out,
    output logic               busy,
    output logic               timeout_err,
    output logic [LEVEL_W-1:0] fifo_level
);

    localparam logic [31:0] CNT_LAST = TIMEOUT_CYCLES - 32'd1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_ack_sync;
    logic               w_ack_s;
    logic [31:0]        r_pio;
    logic [SEQ_W-1:0]   r_seq;
    logic [31:0]        r_cnt;
    logic               r_to_fired;
    logic               r_err;

    logic               w_push;
    logic               w_empty;
    logic               w_full;
    logic [FIFO_W-1:0]  w_head;

    logic               w_pop;
    logic               w_load;
    logic               w_set_stb;
    logic               w_clr_stb;
    logic               w_seq_inc;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic               w_err_set;

    assign w_ack_s     = r_ack_sync[1];
    assign msg_ready   = !w_full;
    assign w_push      = msg_valid && msg_ready;
    assign pio_out     = r_pio;
    assign busy        = (r_state != IDLE);
    assign timeout_err = r_err;

    mailbox_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata ({msg_type, msg_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (fifo_level)
    );

    // Two-flop synchronizer for the HPS acknowledge level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[0], hps_ack};
        end
    end

    // Handshake FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes; a stale high ack holds IDLE off the FIFO
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_set_stb   = 1'b0;
        w_clr_stb   = 1'b0;
        w_seq_inc   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !w_ack_s) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_set_stb   = 1'b1;
                w_cnt_clr   = 1'b1;
                w_state_nxt = VALID;
            end
            VALID: begin
                if (r_cnt == CNT_LAST) begin
                    w_err_set = !r_to_fired;
                end else begin
                    w_cnt_inc = 1'b1;
                end
                if (w_ack_s) begin
                    w_clr_stb   = 1'b1;
                    w_seq_inc   = 1'b1;
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!w_ack_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // PIO word and sequence number; the payload field holds until the next pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pio <= '0;
            r_seq <= '0;
        end else begin
            if (w_load) begin
                r_pio <= {1'b0, w_head[FIFO_W-1 -: TYPE_W], r_seq, w_head[DATA_W-1:0]};
            end else if (w_set_stb) begin
                r_pio[PIO_STB] <= 1'b1;
            end else if (w_clr_stb) begin
                r_pio[PIO_STB] <= 1'b0;
            end
            if (w_seq_inc) begin
                r_seq <= r_seq + SEQ_W'(1);
            end
        end
    end

    // Ack timeout counter; saturates at its last value and fires the error once per VALID visit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_to_fired <= 1'b0;
        end else begin
            if (w_cnt_clr) begin
                r_cnt      <= '0;
                r_to_fired <= 1'b0;
            end else begin
                if (w_cnt_inc) begin
                    r_cnt <= r_cnt + 32'd1;
                end
                if (w_err_set) begin
                    r_to_fired <= 1'b1;
                end
            end
        end
    end

    // Sticky timeout flag; a set in the same cycle as a clear wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (clear_err) begin
            r_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpga2hps_mailbox.sv
// tb/tb_fpga2hps_mailbox.sv - directed self-checking bench for fpga2hps_mailbox
module tb_fpga2hps_mailbox;

    logic        clk = 1'b0;
    logic        reset;
    logic        msg_valid;
    logic        msg_ready;
    logic [3:0]  msg_type;
    logic [23:0] msg_data;
    logic        hps_ack;
    logic        clear_err;
    logic [31:0] pio_out;
    logic        busy;
    logic        timeout_err;
    logic [4:0]  fifo_level;

    int n_checks = 0;
    int n_pass   = 0;

    fpga2hps_mailbox #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .msg_valid   (msg_valid),
        .msg_ready   (msg_ready),
        .msg_type    (msg_type),
        .msg_data    (msg_data),
        .hps_ack     (hps_ack),
        .clear_err   (clear_err),
        .pio_out     (pio_out),
        .busy        (busy),
        .timeout_err (timeout_err),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] pio_word(input logic stb, input logic [3:0] t,
                                             input logic [2:0] s, input logic [23:0] d);
        return {stb, t, s, d};
    endfunction

    // Called at a negedge; returns at the negedge just after the accepting posedge.
    task automatic push_msg(input logic [3:0] t, input logic [23:0] d);
        int k;
        k = 0;
        msg_valid = 1'b1;
        msg_type  = t;
        msg_data  = d;
        while (!msg_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!msg_ready) check_eq("push_wait", {31'b0, msg_ready}, 32'd1);
        @(negedge clk);
        msg_valid = 1'b0;
    endtask

    task automatic wait_strobe(input logic lvl);
        int k;
        k = 0;
        while (pio_out[31] !== lvl && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (pio_out[31] !== lvl) check_eq("strobe_wait", {31'b0, pio_out[31]}, {31'b0, lvl});
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) check_eq("idle_wait", {31'b0, busy}, 32'd0);
    endtask

    task automatic run_hs(output logic [31:0] word);
        wait_strobe(1'b1);
        word    = pio_out;
        hps_ack = 1'b1;
        wait_strobe(1'b0);
        hps_ack = 1'b0;
        wait_idle();
    endtask

    logic [31:0] w;

    initial begin
        reset     = 1'b1;
        msg_valid = 1'b0;
        msg_type  = '0;
        msg_data  = '0;
        hps_ack   = 1'b0;
        clear_err = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("rst_pio",   pio_out, 32'h0);
        check_eq("rst_busy",  {31'b0, busy}, 32'd0);
        check_eq("rst_err",   {31'b0, timeout_err}, 32'd0);
        check_eq("rst_level", {27'b0, fifo_level}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", {31'b0, msg_ready}, 32'd1);

        // Single message latency and ack response
        push_msg(4'h3, 24'hABCDEF);
        check_eq("t1_level_n",  {27'b0, fifo_level}, 32'd1);
        check_eq("t1_pio_n",    pio_out, 32'h0);
        @(negedge clk);
        check_eq("t1_pio_n1",   pio_out, 32'h18ABCDEF);
        check_eq("t1_busy_n1",  {31'b0, busy}, 32'd1);
        check_eq("t1_level_n1", {27'b0, fifo_level}, 32'd0);
        @(negedge clk);
        check_eq("t1_pio_n2",   pio_out, 32'h98ABCDEF);
        hps_ack = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t1_stb_hold", pio_out, 32'h98ABCDEF);
        @(negedge clk);
        check_eq("t1_stb_drop", pio_out, 32'h18ABCDEF);
        hps_ack = 1'b0;
        wait_idle();

        // Sequence numbering through wrap: message k carries seq (k-1) mod 8
        for (int k = 2; k <= 9; k++) begin
            push_msg(4'(k), 24'h100000 + 24'(k));
            run_hs(w);
            check_eq($sformatf("seq_msg%0d", k), w,
                     pio_word(1'b1, 4'(k), 3'((k - 1) % 8), 24'h100000 + 24'(k)));
        end

        // Back-pressure with no ack
        for (int k = 1; k <= 5; k++) push_msg(4'(k), 24'h200000 + 24'(k));
        check_eq("bp_level", {27'b0, fifo_level}, 32'd4);
        check_eq("bp_ready", {31'b0, msg_ready}, 32'd0);
        msg_valid = 1'b1;
        msg_type  = 4'hF;
        msg_data  = 24'hFFFFFF;
        repeat (4) @(negedge clk);
        check_eq("bp_stall_level", {27'b0, fifo_level}, 32'd4);
        check_eq("bp_stall_ready", {31'b0, msg_ready}, 32'd0);
        msg_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            run_hs(w);
            check_eq($sformatf("bp_drain%0d", k), w,
                     pio_word(1'b1, 4'(k), 3'(k), 24'h200000 + 24'(k)));
        end

        // Ack timeout, set-over-clear priority, clear, late ack
        push_msg(4'hA, 24'h5A5A5A);
        wait_strobe(1'b1);
        check_eq("to_err_entry", {31'b0, timeout_err}, 32'd0);
        repeat (15) @(negedge clk);
        check_eq("to_err_15", {31'b0, timeout_err}, 32'd0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check_eq("to_err_16_setwins", {31'b0, timeout_err}, 32'd1);
        @(negedge clk);
        check_eq("to_err_sticky", {31'b0, timeout_err}, 32'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check_eq("to_err_cleared", {31'b0, timeout_err}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("to_err_stays0", {31'b0, timeout_err}, 32'd0);
        check_eq("to_still_valid", pio_out, pio_word(1'b1, 4'hA, 3'd6, 24'h5A5A5A));
        hps_ack = 1'b1;
        wait_strobe(1'b0);
        check_eq("to_late_ack", pio_out, pio_word(1'b0, 4'hA, 3'd6, 24'h5A5A5A));
        hps_ack = 1'b0;
        wait_idle();

        // Stale ack blocks the pop until it drops
        hps_ack = 1'b1;
        repeat (3) @(negedge clk);
        push_msg(4'hC, 24'h00C0DE);
        repeat (4) @(negedge clk);
        check_eq("stale_level", {27'b0, fifo_level}, 32'd1);
        check_eq("stale_busy",  {31'b0, busy}, 32'd0);
        hps_ack = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("stale_busy_t2", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check_eq("stale_pop", pio_out, pio_word(1'b0, 4'hC, 3'd7, 24'h00C0DE));
        check_eq("stale_lvl0", {27'b0, fifo_level}, 32'd0);
        @(negedge clk);
        check_eq("stale_stb", pio_out, pio_word(1'b1, 4'hC, 3'd7, 24'h00C0DE));
        run_hs(w);

        // Reset in VALID with three messages queued
        for (int k = 1; k <= 4; k++) push_msg(4'h7, 24'h300000 + 24'(k));
        wait_strobe(1'b1);
        check_eq("mr_level_pre", {27'b0, fifo_level}, 32'd3);
        check_eq("mr_pio_pre", pio_out, pio_word(1'b1, 4'h7, 3'd0, 24'h300001));
        #1 reset = 1'b1;
        #1;
        check_eq("mr_pio_async",   pio_out, 32'h0);
        check_eq("mr_busy_async",  {31'b0, busy}, 32'd0);
        check_eq("mr_level_async", {27'b0, fifo_level}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("mr_ready_post", {31'b0, msg_ready}, 32'd1);
        check_eq("mr_level_post", {27'b0, fifo_level}, 32'd0);
        check_eq("mr_busy_post",  {31'b0, busy}, 32'd0);
        push_msg(4'h6, 24'h123456);
        wait_strobe(1'b1);
        check_eq("mr_next_msg", pio_out, 32'hB0123456);
        run_hs(w);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
